serial_tx: RTL and testbench

SERIAL_TX -- requirements
Module: serial_tx

---
 rtl/uart_pkg.sv | 17 +
 rtl/serial_parity.sv | 11 +
 rtl/serial_tx.sv | 76 +++++++
 tb/tb_serial_tx.sv | 102 ++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: frame constants and FSM encoding shared by the UART transmitter and receiver.
package uart_pkg;
    localparam int DATA_W = 7;
    localparam int IDX_W = 3;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
    localparam int FRAME_FIXED = 9;
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } uart_state_t;
    function automatic int frame_cycles(input int stop_cycles);
        return FRAME_FIXED + stop_cycles;
    endfunction
endpackage

// File: rtl/serial_parity.sv
// serial_parity: combinational even/odd parity over one payload word.
module serial_parity
    import uart_pkg::*;
#(
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic [DATA_W-1:0] data,
    output logic              parity
);
    assign parity = (^data) ^ PARITY_ODD;
endmodule

// File: rtl/serial_tx.sv
// serial_tx: 7-bit serial transmitter (start, LSB-first data, parity, stop) with registered outputs.
module serial_tx
    import uart_pkg::*;
#(
    parameter bit START_SIG   = 1'b0,
    parameter bit PARITY_ODD  = 1'b0,
    parameter int STOP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              s_out,
    output logic              busy,
    output logic              done
);
    localparam int CW = $clog2(STOP_CYCLES + 1);
    uart_state_t state, state_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [DATA_W-1:0] data, data_n;
    logic par, s_out_n, busy_n, done_n;
    serial_parity #(.PARITY_ODD(PARITY_ODD)) u_par (.data(data), .parity(par));
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= '0;
            cnt   <= '0;
            data  <= '0;
            s_out <= !START_SIG;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            cnt   <= cnt_n;
            data  <= data_n;
            s_out <= s_out_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end
    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        data_n  = data;
        case (state)
            S_IDLE: if (start) begin
                state_n = S_START;
                data_n  = data_in;
            end
            S_START: begin
                state_n = S_DATA;
                idx_n   = '0;
            end
            S_DATA: if (idx == IDX_LAST) state_n = S_PARITY;
                    else idx_n = idx + IDX_W'(1);
            S_PARITY: begin
                state_n = S_STOP;
                cnt_n   = '0;
            end
            S_STOP: if (cnt == CW'(STOP_CYCLES - 1)) begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end else cnt_n = cnt + CW'(1);
            default: state_n = S_IDLE;
        endcase
        // Outputs are computed for the upcoming state so the flops present them in that state's cycle.
        s_out_n = state_n == S_START  ? START_SIG :
                  state_n == S_DATA   ? data[idx_n] :
                  state_n == S_PARITY ? par : !START_SIG;
        busy_n  = state_n != S_IDLE;
        done_n  = state == S_STOP && state_n == S_IDLE;
    end
endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: randomized and directed checks of two serial_tx configurations against a frame-queue model.
module tb_serial_tx;
    import uart_pkg::*;
    typedef logic [2:0] ent_t;
    typedef ent_t ent_q[$];
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [6:0] data_in = '0;
    logic s_out0, busy0, done0, s_out1, busy1, done1;
    int n_cmp = 0;
    int n_bad = 0;
    always #5 clk = ~clk;
    serial_tx u0 (.clk(clk), .rst(rst), .start(start), .data_in(data_in),
                  .s_out(s_out0), .busy(busy0), .done(done0));
    serial_tx #(.START_SIG(1'b1), .PARITY_ODD(1'b1), .STOP_CYCLES(3)) u1 (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in),
        .s_out(s_out1), .busy(busy1), .done(done1));
    // Each entry is {s_out, busy, done} for one future cycle.
    function automatic ent_q frame(input logic [6:0] d, input bit ss, input bit po, input int sc);
        ent_q q;
        q.push_back({ss, 2'b10});
        for (int i = 0; i < 7; i++) q.push_back({d[i], 2'b10});
        q.push_back({(^d) ^ po, 2'b10});
        for (int i = 0; i < sc; i++) q.push_back({!ss, 2'b10});
        q.push_back({!ss, 2'b01});
        return q;
    endfunction
    ent_q q0, q1;
    ent_t e0 = 3'b100;
    ent_t e1 = 3'b000;
    always @(posedge clk) begin
        if (rst) begin
            q0 = {};
            q1 = {};
        end else begin
            if (!e0[1] && start) q0 = frame(data_in, 1'b0, 1'b0, 2);
            if (!e1[1] && start) q1 = frame(data_in, 1'b1, 1'b1, 3);
        end
        e0 = q0.size() > 0 ? q0.pop_front() : 3'b100;
        e1 = q1.size() > 0 ? q1.pop_front() : 3'b000;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic step(input logic st, input logic [6:0] d, input logic r);
        @(negedge clk);
        check("u0_line", {29'd0, s_out0, busy0, done0}, {29'd0, e0});
        check("u1_line", {29'd0, s_out1, busy1, done1}, {29'd0, e1});
        start = st;
        data_in = d;
        rst = r;
    endtask
    initial begin
        logic [10:0] cap;
        int frames0;
        for (int i = 0; i < 3; i++) step(1'b0, 7'h00, 1'b1);
        step(1'b0, 7'h00, 1'b0);
        step(1'b0, 7'h00, 1'b0);
        step(1'b1, 7'h55, 1'b0);
        for (int k = 0; k < 11; k++) begin
            step(1'b0, 7'h00, 1'b0);
            cap[k] = s_out0;
        end
        check("seq55", {21'd0, cap}, {21'd0, 11'b11010101010});
        step(1'b0, 7'h00, 1'b0);
        check("done55", {31'd0, done0}, 32'd1);
        for (int i = 0; i < 3; i++) step(1'b0, 7'h00, 1'b0);
        step(1'b1, 7'h2A, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 7'h2A, 1'b0);
        step(1'b1, 7'h00, 1'b0);
        step(1'b0, 7'h00, 1'b0);
        step(1'b1, 7'h7F, 1'b0);
        step(1'b0, 7'h11, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 7'h3C, 1'b0);
        for (int i = 0; i < 45; i++) step(1'b1, 7'h01, 1'b0);
        step(1'b0, 7'h01, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 7'h01, 1'b0);
        step(1'b1, 7'h5A, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 7'h5A, 1'b0);
        step(1'b1, 7'h5A, 1'b1);
        step(1'b0, 7'h5A, 1'b0);
        check("rst_line", {30'd0, s_out0, busy0}, {30'd0, 2'b10});
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 7'h00, 1'b0);
            if (done0) check("rst_nodone", {31'd0, done0}, 32'd0);
        end
        frames0 = 0;
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(3) == 0, 7'($urandom), $urandom_range(199) == 0);
            if (done0) frames0++;
        end
        for (int i = 0; i < 20; i++) step(1'b0, 7'h00, 1'b0);
        if (frames0 == 0) check("rand_frames", 32'd0, 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
